uart_rx_mon: RTL

Synthesizable, parametrised UART receiver/monitor that replaces bench-only serial sampling of ser_tx. It oversamples a serial line, validates the start bit, and checks parity and stop bits. Received characters go into a first-word-fall-through FIFO with per-entry error flags. It is used inside the SoC as a debug console capture and in benches as a self-checking serial sink.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_mon.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive monitor.
//   PAR_NONE / PAR_EVEN / PAR_ODD : parity mode encodings for the PARITY parameter
//   MAX_DATA_BITS                 : widest supported character
//   rx_state_e                    : receive FSM state
//   rx_entry_t                    : one FIFO entry {brk, ferr, perr, data}
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    // Narrower characters are zero-extended into data.
    typedef struct packed {
        logic                     brk;
        logic                     ferr;
        logic                     perr;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO for received characters.
//   clk, resetn : clock, asynchronous active-low reset
//   wr_en       : push request; wr_data is written when accepted
//   wr_data     : entry to push
//   rd_en       : pop request; ignored while empty
//   rd_data     : head entry, zero while empty
//   rd_valid    : FIFO not empty
//   drop        : push request refused because the FIFO is full and not popping
//   count       : current occupancy, 0..Depth
module uart_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16,
    localparam int unsigned Aw   = $clog2(Depth),
    localparam int unsigned Cw   = Aw + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             rd_valid,
    output logic             drop,
    output logic [Cw-1:0]    count
);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wptr_q, rptr_q;
    logic [Cw-1:0]    count_q;
    logic             empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == Cw'(Depth));
    assign pop   = rd_en && !empty;
    // A same-cycle pop frees the slot, so a push on a full FIFO still lands.
    assign push  = wr_en && (!full || pop);
    assign drop  = wr_en && !push;

    // Pointers are exactly log2(Depth) wide, so they wrap on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + Cw'(push) - Cw'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    assign rd_data  = empty ? '0 : mem_q[rptr_q];
    assign rd_valid = !empty;
    assign count    = count_q;

endmodule

// File: rtl/uart_rx_mon.sv
// UART receiver / serial monitor with error-flagged FWFT capture FIFO.
//   clk, resetn  : clock, asynchronous active-low reset
//   rx           : serial input, idle high, asynchronous to clk
//   cfg_div      : clocks per bit (0 selects CLK_DIV), latched when a frame starts
//   rd_data      : head-of-FIFO character
//   rd_perr      : head entry parity error
//   rd_ferr      : head entry framing error (a stop bit sampled low)
//   rd_brk       : head entry break (data, parity and first stop bit all low)
//   rd_valid     : FIFO not empty
//   rd_ready     : pops the head when rd_valid is high
//   overflow     : sticky, set when a frame is dropped on a full FIFO
//   err_clr      : clears overflow (a new overflow in the same cycle wins)
//   fifo_count   : current FIFO occupancy
//   busy         : receive FSM not idle
module uart_rx_mon
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 106,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    input  logic [15:0]                   cfg_div,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_brk,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          overflow,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam bit       HasParity  = (PARITY != PAR_NONE);
    localparam bit       OddParity  = (PARITY == PAR_ODD);
    localparam bit       SingleStop = (STOP_BITS == 1);
    localparam bit       LastStop   = 1'(STOP_BITS - 1);
    localparam bit [3:0] LastBit    = 4'(DATA_BITS - 1);

    // ---------------------------------------------------------------
    // Input synchroniser and edge detect
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q, rx_fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    // rx_prev_q tracks the line continuously, so a line still low after a
    // framing error gives no edge until it has been seen high again.
    assign rx_fall = rx_prev_q && !rx_s;

    // ---------------------------------------------------------------
    // Receive FSM and baud counter
    // ---------------------------------------------------------------
    rx_state_e            state_q;
    logic [15:0]          div_q, cnt_q, div_sel;
    logic [3:0]           bit_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q, perr_q, ferr_q, stop1_q;
    logic                 tick, push;

    assign div_sel = (cfg_div == 16'd0) ? 16'(CLK_DIV) : cfg_div;
    assign tick    = (cnt_q == 16'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop1_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rx_fall) begin
                        div_q   <= div_sel;
                        // Half a bit to land mid start bit.
                        cnt_q   <= (div_sel >> 1) - 16'd1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (rx_s) begin
                        state_q <= StIdle;  // glitch, not a start bit
                    end else begin
                        cnt_q     <= div_q - 16'd1;
                        bit_q     <= '0;
                        perr_q    <= 1'b0;
                        par_bit_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= div_q - 16'd1;
                        if (bit_q == LastBit) begin
                            stop_idx_q <= 1'b0;
                            ferr_q     <= 1'b0;
                            stop1_q    <= 1'b0;
                            state_q    <= HasParity ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else begin
                        par_bit_q <= rx_s;
                        perr_q    <= (^shift_q) ^ rx_s ^ OddParity;
                        cnt_q     <= div_q - 16'd1;
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - 16'd1;
                    end else if (stop_idx_q == LastStop) begin
                        state_q <= StIdle;  // entry pushed this cycle
                    end else begin
                        stop1_q    <= rx_s;
                        ferr_q     <= ~rx_s;
                        stop_idx_q <= 1'b1;
                        cnt_q      <= div_q - 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign push = (state_q == StStop) && tick && (stop_idx_q == LastStop);

    // Entry is built from the final stop sample taken this cycle.
    rx_entry_t entry;
    always_comb begin
        entry = '0;
        entry.data[DATA_BITS-1:0] = shift_q;
        entry.perr = perr_q;
        entry.ferr = ferr_q | ~rx_s;
        entry.brk  = (shift_q == '0) && (!HasParity || !par_bit_q) &&
                     (SingleStop ? !rx_s : !stop1_q);
    end

    // ---------------------------------------------------------------
    // Capture FIFO and overflow flag
    // ---------------------------------------------------------------
    rx_entry_t head;
    logic      drop, overflow_q;

    uart_rx_fifo #(
        .Width ($bits(rx_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (push),
        .wr_data  (entry),
        .rd_en    (rd_ready),
        .rd_data  (head),
        .rd_valid (rd_valid),
        .drop     (drop),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= (overflow_q && !err_clr) || drop;
        end
    end

    assign overflow = overflow_q;
    assign rd_data  = head.data[DATA_BITS-1:0];
    assign rd_perr  = head.perr;
    assign rd_ferr  = head.ferr;
    assign rd_brk   = head.brk;

    logic unused_head_data;
    assign unused_head_data = ^head.data;

endmodule
